// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: owns the IR, fetches over the shared memory port,
// steps FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives datapath strobes and perf counters.
module core_sequencer #(
  parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        branch_cond,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [31:0] ir,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
  } state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] cycle_q, instret_q;
  logic [6:0]  opcode;

  assign opcode = ir_q[6:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      ir_q      <= RESET_IR;
      cause_q   <= 2'd0;
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cause_q   <= cause_d;
      if (state_q != StTrap) cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    cause_d      = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    retire       = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (opcode)
          OpLui, OpAuipc, OpJal, OpJalr, OpImm, OpReg, OpBranch, OpLoad, OpStore,
          OpFence: state_d = StExecute;
          OpSystem: begin
            state_d = StTrap;
            cause_d = 2'd2;
          end
          default: begin
            state_d = StTrap;
            cause_d = 2'd1;
          end
        endcase
      end
      StExecute: begin
        alu_a_sel = (opcode == OpAuipc) || (opcode == OpJal) || (opcode == OpBranch);
        alu_b_sel = (opcode != OpReg) && (opcode != OpLui) && (opcode != OpFence);
        case (opcode)
          OpBranch, OpFence: begin
            pc_we   = 1'b1;
            pc_sel  = (opcode == OpBranch && branch_cond) ? 2'd1 : 2'd0;
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpLoad, OpStore: state_d = StMem;
          default:         state_d = StWriteback;
        endcase
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OpStore);
        if (mem_ready) begin
          if (opcode == OpStore) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWriteback;
          end
        end
      end
      StWriteback: begin
        rf_we = (ir_q[11:7] != 5'd0);
        case (opcode)
          OpLoad:        wb_sel = 2'd1;
          OpJal, OpJalr: wb_sel = 2'd2;
          OpLui:         wb_sel = 2'd3;
          default:       wb_sel = 2'd0;
        endcase
        pc_we   = 1'b1;
        pc_sel  = (opcode == OpJal) ? 2'd1 : (opcode == OpJalr) ? 2'd2 : 2'd0;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StTrap: ;
      default: begin
        state_d = StTrap;
        cause_d = 2'd1;
      end
    endcase
    // The async reset returns state to FETCH, so the request must be masked explicitly.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'd0;
      rf_we        = 1'b0;
      wb_sel       = 2'd0;
      retire       = 1'b0;
    end
  end

  assign ir          = ir_q;
  assign state       = state_q;
  assign trap        = (state_q == StTrap);
  assign trap_cause  = cause_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed vector table, trap/reset sequences and
// randomized instructions checked against an instruction-level timing model.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic        branch_cond = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, alu_a_sel, alu_b_sel, pc_we, rf_we, retire, trap;
  logic [1:0]  pc_sel, wb_sel, trap_cause;
  logic [2:0]  state;
  logic [31:0] ir, cycle_cnt, instret_cnt;

  int checks = 0;
  int errors = 0;

  core_sequencer dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .branch_cond(branch_cond), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir(ir), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .retire(retire),
    .trap(trap), .trap_cause(trap_cause), .state(state), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    int          mem_cyc;
    int          retires;
    logic        rf_we;
    logic        pc_we;
    logic        mem_we;
    logic        a;
    logic        b;
    logic [1:0]  wb_sel;
    logic [1:0]  pc_sel;
    logic [1:0]  cause;
    logic        done;
    logic [31:0] states;
    logic [31:0] dcyc;
    logic [31:0] dinst;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    int          fw;
    int          mw;
    logic        bc;
    int          cycles;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [1:0]  pc_sel;
    int          mem_cyc;
    logic        mem_we;
  } vec_t;

  task automatic cmp(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one instruction from FETCH until it retires or traps; entered at posedge+1.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw,
                           input logic bc, output obs_t o);
    int fcnt = 0;
    int mcnt = 0;
    logic [31:0] c0 = cycle_cnt;
    logic [31:0] i0 = instret_cnt;
    o = '{default: '0};
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      mem_rdata   = instr;
      branch_cond = bc;
      if (mem_req && !mem_addr_sel) begin
        mem_ready = (fcnt == fw);
        fcnt++;
      end else if (mem_req) begin
        mem_ready = (mcnt == mw);
        mcnt++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      o.cycles++;
      o.states = {o.states[28:0], state};
      if (rf_we) begin o.rf_we = 1'b1; o.wb_sel = wb_sel; end
      if (pc_we) begin o.pc_we = 1'b1; o.pc_sel = pc_sel; end
      if (mem_req && mem_addr_sel) begin
        o.mem_cyc++;
        if (mem_we) o.mem_we = 1'b1;
      end
      if (state == 3'd2) begin o.a = alu_a_sel; o.b = alu_b_sel; end
      if (retire) o.retires++;
      if (trap) begin o.cause = trap_cause; o.done = 1'b1; end
      else if (retire) o.done = 1'b1;
      @(posedge clk);
      #1;
      if (o.done) break;
    end
    o.dcyc  = cycle_cnt - c0;
    o.dinst = instret_cnt - i0;
  endtask

  // Instruction-level expectations from the opcode table and memory wait counts.
  function automatic obs_t model(input logic [31:0] instr, input int fw, input int mw,
                                 input logic bc);
    obs_t e = '{default: '0};
    int   base = 0;
    logic writes = 1'b0;
    case (instr[6:0])
      7'b0110111: begin base = 4; writes = 1; e.wb_sel = 2'd3; end
      7'b0010111: begin base = 4; writes = 1; e.a = 1; e.b = 1; end
      7'b1101111: begin base = 4; writes = 1; e.wb_sel = 2'd2; e.pc_sel = 2'd1; e.a = 1; e.b = 1; end
      7'b1100111: begin base = 4; writes = 1; e.wb_sel = 2'd2; e.pc_sel = 2'd2; e.b = 1; end
      7'b0010011: begin base = 4; writes = 1; e.b = 1; end
      7'b0110011: begin base = 4; writes = 1; end
      7'b1100011: begin base = 3; e.pc_sel = bc ? 2'd1 : 2'd0; e.a = 1; e.b = 1; end
      7'b0000011: begin base = 5 + mw; writes = 1; e.wb_sel = 2'd1; e.mem_cyc = mw + 1; e.b = 1; end
      7'b0100011: begin base = 4 + mw; e.mem_cyc = mw + 1; e.mem_we = 1; e.b = 1; end
      7'b0001111: base = 3;
      7'b1110011: e.cause = 2'd2;
      default:    e.cause = 2'd1;
    endcase
    e.done = 1'b1;
    if (e.cause != 2'd0) begin
      e.cycles = fw + 3;
      e.dcyc   = 32'(fw + 2);
    end else begin
      e.cycles  = base + fw;
      e.dcyc    = 32'(e.cycles);
      e.retires = 1;
      e.dinst   = 32'd1;
      e.pc_we   = 1'b1;
      e.rf_we   = writes && (instr[11:7] != 5'd0);
    end
    return e;
  endfunction

  task automatic compare(input string tag, input obs_t o, input obs_t e, input logic alu);
    cmp({tag, " done"}, o.done, e.done);
    cmp({tag, " cycles"}, o.cycles, e.cycles);
    cmp({tag, " retires"}, o.retires, e.retires);
    cmp({tag, " rf_we"}, o.rf_we, e.rf_we);
    if (e.rf_we) cmp({tag, " wb_sel"}, o.wb_sel, e.wb_sel);
    cmp({tag, " pc_we"}, o.pc_we, e.pc_we);
    if (e.pc_we) cmp({tag, " pc_sel"}, o.pc_sel, e.pc_sel);
    cmp({tag, " mem_cyc"}, o.mem_cyc, e.mem_cyc);
    cmp({tag, " mem_we"}, o.mem_we, e.mem_we);
    cmp({tag, " trap_cause"}, o.cause, e.cause);
    cmp({tag, " cycle_delta"}, o.dcyc, e.dcyc);
    cmp({tag, " instret_delta"}, o.dinst, e.dinst);
    if (alu) begin
      cmp({tag, " alu_a_sel"}, o.a, e.a);
      cmp({tag, " alu_b_sel"}, o.b, e.b);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // After a trap: counters frozen, no requests, trap held; then reset.
  task automatic trap_hold(input string tag, input logic [1:0] cause);
    logic [31:0] c0 = cycle_cnt;
    repeat (3) begin
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    cmp({tag, " frozen cycle_cnt"}, cycle_cnt, c0);
    cmp({tag, " mem_req"}, mem_req, 0);
    cmp({tag, " trap"}, trap, 1);
    cmp({tag, " held cause"}, trap_cause, cause);
    do_reset();
  endtask

  vec_t vecs[10];
  obs_t o, e;

  initial begin
    vecs[0] = '{32'h00500093, 0, 0, 1'b0, 4, 1'b1, 2'd0, 2'd0, 0, 1'b0};
    vecs[1] = '{32'h0000A103, 0, 2, 1'b0, 7, 1'b1, 2'd1, 2'd0, 3, 1'b0};
    vecs[2] = '{32'h00000463, 0, 0, 1'b1, 3, 1'b0, 2'd0, 2'd1, 0, 1'b0};
    vecs[3] = '{32'h00000463, 0, 0, 1'b0, 3, 1'b0, 2'd0, 2'd0, 0, 1'b0};
    vecs[4] = '{32'h0080006F, 0, 0, 1'b0, 4, 1'b0, 2'd0, 2'd1, 0, 1'b0};
    vecs[5] = '{32'h000080E7, 0, 0, 1'b0, 4, 1'b1, 2'd2, 2'd2, 0, 1'b0};
    vecs[6] = '{32'h123452B7, 0, 0, 1'b0, 4, 1'b1, 2'd3, 2'd0, 0, 1'b0};
    vecs[7] = '{32'h0020A023, 1, 0, 1'b0, 5, 1'b0, 2'd0, 2'd0, 1, 1'b1};
    vecs[8] = '{32'h0000000F, 0, 0, 1'b0, 3, 1'b0, 2'd0, 2'd0, 0, 1'b0};
    vecs[9] = '{32'h00500093, 2, 0, 1'b0, 6, 1'b1, 2'd0, 2'd0, 0, 1'b0};

    @(posedge clk);
    #1;
    cmp("reset mem_req", mem_req, 0);
    cmp("reset state", state, 0);
    cmp("reset ir", ir, 32'h00000013);
    cmp("reset trap", trap, 0);
    cmp("reset cycle_cnt", cycle_cnt, 0);
    cmp("reset instret_cnt", instret_cnt, 0);
    rst = 1'b0;

    run_instr(32'h00500093, 0, 0, 1'b0, o);
    cmp("addi state trace", o.states, 32'o0124);
    cmp("addi cycle_cnt", cycle_cnt, 4);
    cmp("addi instret_cnt", instret_cnt, 1);
    cmp("addi ir", ir, 32'h00500093);

    for (int i = 0; i < 10; i++) begin
      e = '{default: '0};
      e.done    = 1'b1;
      e.cycles  = vecs[i].cycles;
      e.retires = 1;
      e.rf_we   = vecs[i].rf_we;
      e.wb_sel  = vecs[i].wb_sel;
      e.pc_we   = 1'b1;
      e.pc_sel  = vecs[i].pc_sel;
      e.mem_cyc = vecs[i].mem_cyc;
      e.mem_we  = vecs[i].mem_we;
      e.dcyc    = 32'(vecs[i].cycles);
      e.dinst   = 32'd1;
      run_instr(vecs[i].instr, vecs[i].fw, vecs[i].mw, vecs[i].bc, o);
      compare($sformatf("vec%0d", i), o, e, 1'b0);
    end

    run_instr(32'hFFFFFFFF, 0, 0, 1'b0, o);
    cmp("illegal cause", o.cause, 1);
    cmp("illegal retires", o.retires, 0);
    trap_hold("illegal", 2'd1);
    run_instr(32'h00000073, 0, 0, 1'b0, o);
    cmp("ecall cause", o.cause, 2);
    trap_hold("ecall", 2'd2);

    // Reset while fetch is stalled.
    run_instr(32'h00500093, 0, 0, 1'b0, o);
    mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    cmp("midrst mem_req", mem_req, 0);
    cmp("midrst pc_we", pc_we, 0);
    cmp("midrst cycle_cnt", cycle_cnt, 0);
    cmp("midrst instret_cnt", instret_cnt, 0);
    cmp("midrst ir", ir, 32'h00000013);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    cmp("post-rst mem_req", mem_req, 1);
    cmp("post-rst state", state, 0);
    @(posedge clk);
    #1;
    cmp("post-rst wait cycle_cnt", cycle_cnt, 1);
    do_reset();

    for (int n = 0; n < 60; n++) begin
      logic [6:0]  ops[12];
      logic [31:0] instr;
      int fw, mw;
      logic bc;
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0110011,
              7'b1100011, 7'b0000011, 7'b0100011, 7'b0001111, 7'b1110011, 7'b0000000};
      instr = $urandom;
      instr[6:0] = ops[$urandom_range(0, 11)];
      if (instr[6:0] == 7'b0000000) instr[6:0] = 7'($urandom);
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      bc = 1'($urandom_range(0, 1));
      e = model(instr, fw, mw, bc);
      run_instr(instr, fw, mw, bc, o);
      compare($sformatf("rnd%0d %h", n, instr), o, e,
              (e.cause == 2'd0) && (instr[6:0] != 7'b0110111));
      if (e.cause != 2'd0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RV32I core. It owns the instruction register, fetches over the single shared memory port, and classifies the latched opcode. It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, driving datapath select and write-enable strobes. It also arbitrates the memory port between instruction fetch and load/store, and keeps cycle/retire counters.

## Interface
- RESET_IR, 32'h0000_0013, IR value loaded at reset (ADDI x0,x0,0).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- mem_rdata  in  32  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completes the current request this cycle; ignored while mem_req=0.
- branch_cond  in  1  branch comparator result for the current IR; sampled in EXECUTE only.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = read.
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (load/store).
- ir  out  32  instruction register, feeds the decoder and immediate generator.
- alu_a_sel  out  1  0 = rs1, 1 = PC.
- alu_b_sel  out  1  0 = rs2, 1 = immediate.
- pc_we  out  1  PC write strobe.
- pc_sel  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = (rs1+imm)&~1 (JALR).
- rf_we  out  1  register-file write strobe.
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = immediate (LUI).
- retire  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  sticky; the sequencer is stopped.
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = SYSTEM (ECALL/EBREAK/CSR).
- state  out  3  current state, for debug.
- cycle_cnt  out  32  cycles since reset.
- instret_cnt  out  32  retired instructions.

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5. Codes 6 and 7 go to TRAP with cause 1.
- **FETCH**
  - Drive mem_req=1, mem_we=0, mem_addr_sel=0.
  - Hold until mem_ready=1, then load ir from mem_rdata and go to DECODE.
- **DECODE**
  - Takes exactly 1 cycle.
  - Legal opcodes (ir[6:0]): LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP-IMM 0010011, OP 0110011, BRANCH 1100011, LOAD 0000011, STORE 0100011, FENCE 0001111, SYSTEM 1110011.
  - Any other opcode, including ir[1:0]≠11, goes to TRAP with cause 1.
  - SYSTEM goes to TRAP with cause 2.
  - All other legal opcodes go to EXECUTE.
- **EXECUTE** (1 cycle); ALU select values drive what the datapath computes this cycle:
  - OP: a=rs1, b=rs2.
  - OP-IMM, LOAD, STORE, JALR: a=rs1, b=imm.
  - AUIPC, JAL, BRANCH: a=PC, b=imm.
  - LUI: don't care.
  - BRANCH: pc_we=1, pc_sel=1 if branch_cond else 0, retire=1, then FETCH.
  - FENCE: pc_we=1, pc_sel=0, retire=1, then FETCH. FENCE is a NOP.
  - LOAD and STORE go to MEM. Everything else goes to WRITEBACK.
- **MEM**
  - Drive mem_req=1, mem_addr_sel=1, mem_we=1 for STORE; hold until mem_ready=1.
  - STORE on ready: pc_we=1, pc_sel=0, retire=1, then FETCH.
  - LOAD on ready: go to WRITEBACK. Load data is captured by the datapath.
- **WRITEBACK** (1 cycle)
  - rf_we=1 only when ir[11:7]≠0.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, otherwise 0.
  - pc_we=1 with pc_sel: JAL=1, JALR=2, otherwise 0.
  - retire=1, then FETCH.
- **TRAP**
  - All strobes are 0, trap=1, trap_cause is held.
  - Only rst leaves TRAP.
- Strobe rules:
  - Strobes are combinational from state, ir and the listed inputs.
  - Every strobe not stated is 0.
  - alu_a_sel and alu_b_sel are 0 outside EXECUTE.
- Counters:
  - cycle_cnt increments every cycle outside reset and outside TRAP.
  - instret_cnt increments on each retire pulse.
  - Both wrap mod 2^32.

## Timing
- Reset (async assert) takes effect immediately and forces:
  - state=FETCH, ir=RESET_IR;
  - trap=0, trap_cause=0;
  - both counters=0;
  - every strobe forced 0 while rst=1, including mem_req.
- First mem_req=1 is in the first cycle after rst deasserts.
- Cycles with zero-wait memory (mem_ready=1 on the first request cycle):
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH, FENCE: 3.
- Each memory wait cycle adds one cycle to FETCH or MEM. Request outputs stay stable while waiting.
- Fetch and data access never overlap. mem_addr_sel alone distinguishes the two requesters.
- mem_ready with mem_req=0 has no effect.
- Reset mid-FETCH or mid-MEM abandons the request. No retire and no pc_we are issued for it.

## Test plan
- **Reset, then ADDI x1,x0,5 (32'h00500093), zero-wait.** States 0→1→2→4→0; rf_we=1, wb_sel=0 in cycle 4; retire once; instret_cnt=1, cycle_cnt=4.
- **LW x2,0(x1) (32'h0000A103), mem_ready low 2 cycles in MEM.** MEM lasts 3 cycles with mem_addr_sel=1, mem_we=0; then WRITEBACK with wb_sel=1, rf_we=1; total 7 cycles.
- **BEQ (32'h00000463), branch_cond=1, then branch_cond=0.** EXECUTE pc_we=1 with pc_sel=1, then pc_sel=0; no rf_we; 3 cycles each.
- **JAL x0 (32'h0080006F) and JALR x1 (32'h000080E7).** JAL: rf_we=0 (rd=0), pc_sel=1. JALR: wb_sel=2, rf_we=1, pc_sel=2.
- **Opcode 7'b1111111 (32'hFFFFFFFF), then ECALL (32'h00000073) after reset.** First case: TRAP, trap_cause=1, no retire. Second case: trap_cause=2. In both, mem_req stays 0 and cycle_cnt freezes until rst.
- **rst asserted during FETCH wait, then released.** Outputs are 0 immediately and counters are 0; FETCH restarts with ir=32'h00000013.
